// File: rtl/ca_run_ctrl.sv
// Rule 110 run sequencer: owns the cell row, loads a seed byte-serially, runs the
// step datapath for a programmed number of generations and streams row snapshots.
module ca_run_ctrl #(
  parameter int WIDTH = 256,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [IN_W-1:0]   seed_data,
  output logic              seed_ready,
  input  logic              start,
  input  logic [CNT_W-1:0]  gen_count,
  input  logic              snap_each,
  input  logic              abort,
  output logic [WIDTH-1:0]  ca_cur,
  output logic              ca_ena,
  input  logic [WIDTH-1:0]  ca_next,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  gen_idx
);

  localparam int NWORDS = WIDTH / OUT_W;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0]    K_LAST   = KW'(NWORDS - 1);
  localparam logic [KW-1:0]    K_ZERO   = KW'(0);
  localparam logic [KW-1:0]    K_ONE    = KW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DUMP = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   row_r, row_s, row_sh_s;
  logic [KW-1:0]      k_r, k_s;
  logic [CNT_W-1:0]   left_r, left_s;
  logic [CNT_W-1:0]   gen_idx_r, gen_idx_s;
  logic               snap_r, snap_s;
  logic               done_s;

  logic               seed_ready_r, ca_ena_r, out_valid_r, out_last_r, busy_r, done_r;
  logic [OUT_W-1:0]   out_data_r;

  // Next-state, row, word index and counter computation
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    k_s       = k_r;
    left_s    = left_r;
    gen_idx_s = gen_idx_r;
    snap_s    = snap_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (seed_valid) begin
          row_s = {row_r[WIDTH-IN_W-1:0], seed_data};
        end else begin
          row_s = row_r;
        end
        if (start) begin
          left_s    = gen_count;
          snap_s    = snap_each;
          gen_idx_s = CNT_ZERO;
          k_s       = K_ZERO;
          state_s   = (gen_count != CNT_ZERO) ? STEP : DUMP;
        end else begin
          state_s = IDLE;
        end
      end
      STEP: begin
        row_s     = ca_next;
        left_s    = left_r - CNT_ONE;
        gen_idx_s = gen_idx_r + CNT_ONE;
        if (snap_r || (left_r == CNT_ONE)) begin
          state_s = DUMP;
        end else begin
          state_s = STEP;
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (k_r == K_LAST) begin
            k_s = K_ZERO;
            if (snap_r && (left_r != CNT_ZERO)) begin
              state_s = STEP;
            end else begin
              state_s = IDLE;
              done_s  = 1'b1;
            end
          end else begin
            k_s = k_r + K_ONE;
          end
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        state_s = IDLE;
        k_s     = K_ZERO;
      end
    endcase
    // abort outranks both a pending start and a completing handshake
    if (abort && (state_r != IDLE)) begin
      state_s   = IDLE;
      k_s       = K_ZERO;
      row_s     = row_r;
      gen_idx_s = gen_idx_r;
      left_s    = left_r;
      done_s    = 1'b0;
    end else begin
      done_s = done_s;
    end
    row_sh_s = row_s << (OUT_W * int'(k_s));
  end

  // State, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      row_r        <= {WIDTH{1'b0}};
      k_r          <= K_ZERO;
      left_r       <= CNT_ZERO;
      gen_idx_r    <= CNT_ZERO;
      snap_r       <= 1'b0;
      seed_ready_r <= 1'b1;
      ca_ena_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= {OUT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_r        <= row_s;
      k_r          <= k_s;
      left_r       <= left_s;
      gen_idx_r    <= gen_idx_s;
      snap_r       <= snap_s;
      seed_ready_r <= (state_s == IDLE);
      ca_ena_r     <= (state_s == STEP);
      out_valid_r  <= (state_s == DUMP);
      out_last_r   <= (state_s == DUMP) && (k_s == K_LAST);
      out_data_r   <= (state_s == DUMP) ? row_sh_s[WIDTH-1 -: OUT_W] : {OUT_W{1'b0}};
      busy_r       <= (state_s != IDLE);
      done_r       <= done_s;
    end
  end

  assign ca_cur     = row_r;
  assign gen_idx    = gen_idx_r;
  assign seed_ready = seed_ready_r;
  assign ca_ena     = ca_ena_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_data   = out_data_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Bench for ca_run_ctrl: a Rule 110 step unit on ca_*, a snapshot-queue model and
// directed runs covering seed load, plain/snapshot runs, backpressure, abort and reset.
module tb_ca_run_ctrl;
  localparam int WIDTH = 256, IN_W = 8, OUT_W = 16, CNT_W = 16;
  localparam int NWORDS = WIDTH / OUT_W;

  logic              clk = 1'b0;
  logic              rst, seed_valid, seed_ready, start, snap_each, abort;
  logic [IN_W-1:0]   seed_data;
  logic [CNT_W-1:0]  gen_count, gen_idx;
  logic [WIDTH-1:0]  ca_cur, ca_next;
  logic              ca_ena, out_valid, out_last, out_ready, busy, done;
  logic [OUT_W-1:0]  out_data;

  always #5 clk = ~clk;

  // Rule 110: the new cell is bit {left,centre,right} of the rule number; zero boundaries.
  function automatic logic [WIDTH-1:0] rule110(input logic [WIDTH-1:0] r);
    logic [7:0]       rule;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] nx;
    rule = 8'd110;
    ext  = {1'b0, r, 1'b0};
    for (int i = 0; i < WIDTH; i++) nx[i] = rule[ext[i+2 -: 3]];
    return nx;
  endfunction

  assign ca_next = rule110(ca_cur);

  ca_run_ctrl #(.WIDTH(WIDTH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
    .seed_ready(seed_ready), .start(start), .gen_count(gen_count), .snap_each(snap_each),
    .abort(abort), .ca_cur(ca_cur), .ca_ena(ca_ena), .ca_next(ca_next),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .gen_idx(gen_idx)
  );

  int total = 0, passed = 0;

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // model state
  logic [WIDTH-1:0] m_row;
  logic [OUT_W:0]   m_q[$];
  logic             m_pending;
  int               m_gen, m_ena_exp, ena_seen, done_cnt, hs_cnt;
  logic [OUT_W-1:0] last_word;
  logic [OUT_W-1:0] snap_last[$];

  task automatic push_row(input logic [WIDTH-1:0] r);
    for (int k = 0; k < NWORDS; k++)
      m_q.push_back({(k == NWORDS - 1), r[WIDTH-1-OUT_W*k -: OUT_W]});
  endtask

  // compare process: inputs settle after posedge, so negedge sees the next edge's inputs
  initial begin
    logic [OUT_W:0] exp;
    m_row = '0; m_pending = 1'b0; m_gen = 0; m_ena_exp = 0;
    ena_seen = 0; done_cnt = 0; hs_cnt = 0; last_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_row = '0; m_q.delete(); m_pending = 1'b0; m_gen = 0;
      end else begin
        if (out_valid) begin
          if (m_q.size() == 0) begin
            check("unexpected_word", 1'b0, 64'(out_data), 64'd0);
          end else begin
            exp = m_q[0];
            check("out_data", out_data == exp[OUT_W-1:0], 64'(out_data), 64'(exp[OUT_W-1:0]));
            check("out_last", out_last == exp[OUT_W], 64'(out_last), 64'(exp[OUT_W]));
            if (out_ready && !abort) begin
              m_q.pop_front();
              hs_cnt++;
              last_word = out_data;
              if (out_last) snap_last.push_back(out_data);
            end
          end
        end
        if (ca_ena) ena_seen++;
        if (done) begin
          check("done_expected", m_pending, 64'(done), 64'd1);
          check("gen_idx_at_done", gen_idx == CNT_W'(m_gen), 64'(gen_idx), 64'(m_gen));
          check("ena_cycles", ena_seen == m_ena_exp, 64'(ena_seen), 64'(m_ena_exp));
          check("queue_drained", m_q.size() == 0, 64'(m_q.size()), 64'd0);
          m_pending = 1'b0;
          done_cnt++;
        end
        if (busy && abort) begin
          m_q.delete();
          m_pending = 1'b0;
        end else if (!busy) begin
          if (seed_valid && seed_ready) m_row = {m_row[WIDTH-IN_W-1:0], seed_data};
          if (start) begin
            m_pending = 1'b1;
            m_gen     = int'(gen_count);
            m_ena_exp = int'(gen_count);
            ena_seen  = 0;
            if (gen_count == 0) push_row(m_row);
            for (int g = 0; g < int'(gen_count); g++) begin
              m_row = rule110(m_row);
              if (snap_each || g == int'(gen_count) - 1) push_row(m_row);
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed();
    for (int i = 0; i < WIDTH / IN_W; i++) begin
      seed_valid = 1'b1;
      seed_data  = (i == WIDTH / IN_W - 1) ? 8'h01 : 8'h00;
      cyc();
    end
    seed_valid = 1'b0;
  endtask

  task automatic run_start(input int gc, input logic se);
    gen_count = CNT_W'(gc);
    snap_each = se;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 500 && hs_cnt < target; i++) cyc();
    check("handshake_timeout", hs_cnt >= target, 64'(hs_cnt), 64'(target));
  endtask

  task automatic wait_done();
    int d;
    d = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == d; i++) cyc();
    check("done_timeout", done_cnt != d, 64'(done_cnt), 64'(d + 1));
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    int base, d0;
    rst = 1'b1; seed_valid = 1'b0; seed_data = '0; start = 1'b0; gen_count = '0;
    snap_each = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("rst_seed_ready", seed_ready == 1'b1, 64'(seed_ready), 64'd1);
    check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check("rst_out_last", out_last == 1'b0, 64'(out_last), 64'd0);
    check("rst_out_data", out_data == 16'h0000, 64'(out_data), 64'd0);
    check("rst_done", done == 1'b0, 64'(done), 64'd0);
    check("rst_ca_ena", ca_ena == 1'b0, 64'(ca_ena), 64'd0);
    check("rst_gen_idx", gen_idx == 16'd0, 64'(gen_idx), 64'd0);
    check("rst_row", ca_cur == '0, ca_cur[63:0], 64'd0);
    rst = 1'b0;

    // hand-computed Rule 110 growth from a single LSB cell: 1 -> 3 -> 7 -> D
    r = '0; r[0] = 1'b1;
    r = rule110(r); check("model_gen1", r == WIDTH'(3), r[63:0], 64'h3);
    r = rule110(r); check("model_gen2", r == WIDTH'(7), r[63:0], 64'h7);
    r = rule110(r); check("model_gen3", r == WIDTH'(13), r[63:0], 64'hD);

    // seed dumped unchanged
    load_seed();
    run_start(0, 1'b0);
    wait_done();
    check("t1_last_word", last_word == 16'h0001, 64'(last_word), 64'h1);
    check("t1_gen_idx", gen_idx == 16'd0, 64'(gen_idx), 64'd0);
    check("t1_ena", ena_seen == 0, 64'(ena_seen), 64'd0);

    // three generations, stalled at word 7
    load_seed();
    base = hs_cnt;
    run_start(3, 1'b0);
    wait_hs(base + 7);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid", out_valid == 1'b1, 64'(out_valid), 64'd1);
      check("stall_data", out_data == 16'h0000, 64'(out_data), 64'd0);
      check("stall_last", out_last == 1'b0, 64'(out_last), 64'd0);
    end
    check("stall_no_advance", hs_cnt == base + 7, 64'(hs_cnt), 64'(base + 7));
    out_ready = 1'b1;
    wait_done();
    check("t2_last_word", last_word == 16'h000D, 64'(last_word), 64'hD);
    check("t2_gen_idx", gen_idx == 16'd3, 64'(gen_idx), 64'd3);
    check("t2_ena", ena_seen == 3, 64'(ena_seen), 64'd3);

    // snapshot after every generation
    load_seed();
    snap_last.delete();
    d0 = done_cnt;
    run_start(3, 1'b1);
    wait_done();
    repeat (4) cyc();
    check("t3_snap_count", snap_last.size() == 3, 64'(snap_last.size()), 64'd3);
    if (snap_last.size() == 3) begin
      check("t3_snap0", snap_last[0] == 16'h0003, 64'(snap_last[0]), 64'h3);
      check("t3_snap1", snap_last[1] == 16'h0007, 64'(snap_last[1]), 64'h7);
      check("t3_snap2", snap_last[2] == 16'h000D, 64'(snap_last[2]), 64'hD);
    end
    check("t3_one_done", done_cnt == d0 + 1, 64'(done_cnt), 64'(d0 + 1));

    // abort at word 4 with a competing start
    load_seed();
    base = hs_cnt;
    run_start(2, 1'b0);
    wait_hs(base + 4);
    d0 = done_cnt;
    abort = 1'b1; start = 1'b1; gen_count = 16'd5;
    cyc();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("abort_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check("abort_gen_idx", gen_idx == 16'd2, 64'(gen_idx), 64'd2);
    check("abort_row", ca_cur == WIDTH'(7), ca_cur[63:0], 64'h7);
    repeat (3) cyc();
    check("abort_start_ignored", busy == 1'b0, 64'(busy), 64'd0);
    check("abort_no_done", done_cnt == d0, 64'(done_cnt), 64'(d0));
    run_start(0, 1'b0);
    wait_done();
    check("post_abort_word", last_word == 16'h0007, 64'(last_word), 64'h7);
    check("post_abort_gen_idx", gen_idx == 16'd0, 64'(gen_idx), 64'd0);

    // reset in the middle of a long run
    load_seed();
    run_start(100, 1'b0);
    repeat (5) cyc();
    check("long_run_stepping", ca_ena == 1'b1, 64'(ca_ena), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_busy", busy == 1'b0, 64'(busy), 64'd0);
    check("mid_rst_row", ca_cur == '0, ca_cur[63:0], 64'd0);
    check("mid_rst_gen_idx", gen_idx == 16'd0, 64'(gen_idx), 64'd0);
    check("mid_rst_seed_ready", seed_ready == 1'b1, 64'(seed_ready), 64'd1);
    check("mid_rst_ena", ca_ena == 1'b0, 64'(ca_ena), 64'd0);
    repeat (3) cyc();
    check("end_queue_empty", m_q.size() == 0, 64'(m_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
